present_enc_ctrl: RTL and testbench

PRESENT_ENC_CTRL -- requirements
Module: present_enc_ctrl

---
 rtl/present_enc_ctrl.sv | 121 ++++++++++++
 tb/tb_present_enc_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_enc_ctrl.sv
// PRESENT-80 iterative encryption engine: one round per clock, valid/ready handshake
// on both sides, with the ciphertext held in an output register until it is consumed.
module present_enc_ctrl #(
  parameter int size      = 64,
  parameter int keySize   = 80,
  parameter int numRounds = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [keySize-1:0] in_key,
  input  logic [size-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [size-1:0]    out_data,
  output logic               busy,
  output logic [4:0]         round_idx
);

  localparam logic [4:0] LAST_ROUND = 5'(numRounds - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

  state_t              state, state_nxt;
  logic [size-1:0]     blk;
  logic [keySize-1:0]  key;
  logic [size-1:0]     rk, mixed, sub, perm;
  logic [keySize-1:0]  key_rot, key_nxt;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  // Round datapath: key add, substitution layer, bit permutation, key schedule step.
  always_comb begin
    rk    = key[keySize-1 -: size];
    mixed = blk ^ rk;
    sub   = '0;
    for (int unsigned n = 0; n < size / 4; n++) begin
      sub[4*n +: 4] = sbox(mixed[4*n +: 4]);
    end
    perm = '0;
    for (int unsigned i = 0; i < size - 1; i++) begin
      perm[(16 * i) % (size - 1)] = sub[i];
    end
    perm[size-1] = sub[size-1];

    key_rot                        = {key[keySize-62:0], key[keySize-1:keySize-61]};
    key_nxt                        = key_rot;
    key_nxt[keySize-1:keySize-4]   = sbox(key_rot[keySize-1:keySize-4]);
    key_nxt[19:15]                 = key_rot[19:15] ^ round_idx;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (round_idx == LAST_ROUND) state_nxt = FINAL;
      end
      FINAL: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      blk       <= '0;
      key       <= '0;
      round_idx <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            blk       <= in_data;
            key       <= in_key;
            round_idx <= 5'd1;
          end
        end
        RUN: begin
          blk <= perm;
          key <= key_nxt;
          // Counter parks at the last round so FINAL still sees 31 and never wraps.
          if (round_idx != LAST_ROUND) round_idx <= round_idx + 5'd1;
        end
        FINAL: begin
          out_data  <= blk ^ rk;
          out_valid <= 1'b1;
          round_idx <= '0;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_present_enc_ctrl.sv
// Bench for present_enc_ctrl: known-answer table, random requests against a
// behavioural PRESENT-80 model, and hand-written handshake/reset sequences.
module tb_present_enc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] in_key;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic [4:0]  round_idx;

  int tests = 0;
  int fails = 0;

  present_enc_ctrl #(.size(64), .keySize(80), .numRounds(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .round_idx(round_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [79:0] key;
    logic [63:0] pt;
    logic [63:0] ct;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Straight from the cipher definition: 31 rounds, then whitening with round key 32.
  function automatic logic [63:0] ref_enc(input logic [79:0] key_in, input logic [63:0] pt);
    int          sb[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    logic [79:0] k = key_in;
    logic [63:0] s = pt;
    logic [63:0] t;
    for (int r = 1; r < 32; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = 4'(sb[k[79:76]]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [79:0] rnd80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One full transaction with random out_ready noise while running and in DONE.
  task automatic do_req(input logic [79:0] key, input logic [63:0] pt,
                        output logic [63:0] ct, output int lat);
    bit bad_busy = 0;
    chk("req_in_ready", 80'(in_ready), 80'd1);
    in_key = key; in_data = pt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_key = ~key; in_data = ~pt;
    chk("accept_round_idx", 80'(round_idx), 80'd1);
    lat = 0;
    while (!out_valid && lat < 64) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) bad_busy = 1;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("busy_during_run", 80'(bad_busy), 80'd0);
    ct = out_data;
    repeat ($urandom_range(0, 3)) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
    end
    chk("done_hold", 80'(out_data), 80'(ct));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_handshake_valid", 80'(out_valid), 80'd0);
    chk("out_handshake_ready", 80'(in_ready), 80'd1);
  endtask

  initial begin
    logic [63:0] ct;
    int          lat;
    logic [79:0] k;
    logic [63:0] p;
    bit          bad;
    int          wait_cnt;
    logic [79:0] bk[4];
    logic [63:0] bp[4];
    logic [63:0] res[4];
    int          acc, got, ov_cyc, cyc;

    vecs[0] = '{80'h0, 64'h0, 64'h5579C1387B228445};
    vecs[1] = '{80'h0, 64'hFFFFFFFFFFFFFFFF, 64'hA112FFC72F68417B};
    vecs[2] = '{80'hFFFFFFFFFFFFFFFFFFFF, 64'h0, 64'hE72C46C0F5945049};
    vecs[3] = '{80'hFFFFFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2};

    // Reset with in_valid asserted: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; in_key = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_in_ready", 80'(in_ready), 80'd1);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_out_data", 80'(out_data), 80'd0);
    chk("rst_round_idx", 80'(round_idx), 80'd0);

    // out_ready while idle has no effect.
    bad = 0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) bad = 1;
    end
    out_ready = 1'b0;
    chk("idle_out_ready", 80'(bad), 80'd0);

    for (int v = 0; v < 4; v++) begin
      do_req(vecs[v].key, vecs[v].pt, ct, lat);
      chk($sformatf("kat%0d_ct", v), 80'(ct), 80'(vecs[v].ct));
      chk($sformatf("kat%0d_latency", v), 80'(lat), 80'd32);
    end

    // Hold in DONE for 10 cycles with stray in_valid pulses.
    in_key = vecs[3].key; in_data = vecs[3].pt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 64) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("hold_latency", 80'(wait_cnt), 80'd32);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_key = rnd80(); in_data = rnd64();
      @(posedge clk); #1;
      if (out_data !== vecs[3].ct || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1;
    end
    chk("hold_stable", 80'(bad), 80'd0);
    chk("hold_ct", 80'(out_data), 80'(vecs[3].ct));
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_release_ready", 80'(in_ready), 80'd1);
    chk("hold_release_valid", 80'(out_valid), 80'd0);
    @(posedge clk); #1;
    chk("hold_no_stray_accept", 80'(busy), 80'd0);

    // Reset mid-run at round 17 discards the encryption.
    in_key = rnd80(); in_data = rnd64(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_cnt = 0;
    while (round_idx != 5'd17 && wait_cnt < 64) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("midrun_reached_17", 80'(round_idx), 80'd17);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_rst_busy", 80'(busy), 80'd0);
    chk("midrun_rst_valid", 80'(out_valid), 80'd0);
    chk("midrun_rst_round", 80'(round_idx), 80'd0);
    chk("midrun_rst_ready", 80'(in_ready), 80'd1);
    chk("midrun_rst_data", 80'(out_data), 80'd0);
    bad = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad = 1;
    end
    chk("midrun_no_output", 80'(bad), 80'd0);
    do_req(80'h0, 64'h0, ct, lat);
    chk("after_rst_ct", 80'(ct), 80'h5579C1387B228445);
    chk("after_rst_latency", 80'(lat), 80'd32);

    // Reset while DONE drops the pending result.
    in_key = vecs[2].key; in_data = vecs[2].pt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 64) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("done_rst_ct", 80'(out_data), 80'(vecs[2].ct));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("done_rst_valid", 80'(out_valid), 80'd0);
    chk("done_rst_ready", 80'(in_ready), 80'd1);

    // Random requests against the reference model.
    for (int r = 0; r < 10; r++) begin
      k = rnd80(); p = rnd64();
      do_req(k, p, ct, lat);
      chk($sformatf("rand%0d_ct", r), 80'(ct), 80'(ref_enc(k, p)));
      chk($sformatf("rand%0d_latency", r), 80'(lat), 80'd32);
    end

    // Back-to-back: in_valid and out_ready held high.
    for (int i = 0; i < 4; i++) begin
      bk[i] = rnd80(); bp[i] = rnd64(); res[i] = '0;
    end
    acc = 0; got = 0; ov_cyc = -10; cyc = 0;
    bad = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (got < 4 && cyc < 200) begin
      if (out_valid) begin
        res[got] = out_data;
        got++;
        ov_cyc = cyc;
      end
      if (got == 4) in_valid = 1'b0;
      if (in_ready && acc < 4 && in_valid) begin
        if (acc > 0 && cyc != ov_cyc + 1) bad = 1;
        in_key = bk[acc]; in_data = bp[acc];
        acc++;
      end else begin
        in_key = rnd80(); in_data = rnd64();
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_outputs", 80'(got), 80'd4);
    chk("b2b_accepts", 80'(acc), 80'd4);
    chk("b2b_gap", 80'(bad), 80'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b%0d_ct", i), 80'(res[i]), 80'(ref_enc(bk[i], bp[i])));
    end
    chk("b2b_end_ready", 80'(in_ready), 80'd1);
    @(posedge clk); #1;
    chk("b2b_end_idle", 80'(busy), 80'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
